// File: rtl/l2_arb_pkg.sv
// Shared constants and helpers for the L2 memory-side arbiter.
// Optional performance counters are enabled with L2_MEM_ARB_PERF_EN.
package l2_arb_pkg;

    // Default interface widths
    localparam int DEF_NUM_REQ         = 2;
    localparam int DEF_ADDRESS_BITS    = 32;
    localparam int DEF_DATA_BITS       = 64;
    localparam int DEF_MASK_BITS       = 8;
    localparam int DEF_OP_BITS         = 3;
    localparam int DEF_SIZE_BITS       = 3;
    localparam int DEF_SOURCE_BITS     = 8;
    localparam int DEF_PARAM_BITS      = 3;
    localparam int DEF_MAX_OUTSTANDING = 4;

    // Outstanding counters hold up to 15 in-flight requests
    localparam int CNT_W = 4;

    // A-channel opcodes
    localparam logic [2:0] GET         = 3'd4;
    localparam logic [2:0] PUT_FULL    = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Width of the requester index carried in the upper source bits
    function automatic int tag_bits(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/l2_mem_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter
    import l2_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = tag_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic found;
    int   pos;

    // Scan requesters starting at ptr and wrap around; grant the first active one
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Arbitrates NUM_REQ L2 memory-side A channels onto one memory port and
// routes D responses back by the requester tag in the upper source bits.
// Define L2_MEM_ARB_PERF_EN to add grant and stall performance counters.
module l2_mem_arbiter
    import l2_arb_pkg::*;
#(
    parameter  int NUM_REQ         = DEF_NUM_REQ,
    parameter  int ADDRESS_BITS    = DEF_ADDRESS_BITS,
    parameter  int DATA_BITS       = DEF_DATA_BITS,
    parameter  int MASK_BITS       = DEF_MASK_BITS,
    parameter  int OP_BITS         = DEF_OP_BITS,
    parameter  int SIZE_BITS       = DEF_SIZE_BITS,
    parameter  int SOURCE_BITS     = DEF_SOURCE_BITS,
    parameter  int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    localparam int TAG_BITS        = tag_bits(NUM_REQ),
    localparam int PB              = DEF_PARAM_BITS
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                up_a_valid,
    output logic [NUM_REQ-1:0]                up_a_ready,
    input  logic [NUM_REQ*OP_BITS-1:0]        up_a_opcode,
    input  logic [NUM_REQ*SIZE_BITS-1:0]      up_a_size,
    input  logic [NUM_REQ*SOURCE_BITS-1:0]    up_a_source,
    input  logic [NUM_REQ*ADDRESS_BITS-1:0]   up_a_address,
    input  logic [NUM_REQ*MASK_BITS-1:0]      up_a_mask,
    input  logic [NUM_REQ*DATA_BITS-1:0]      up_a_data,
    input  logic [NUM_REQ*PB-1:0]             up_a_param,
    output logic [NUM_REQ-1:0]                up_d_valid,
    input  logic [NUM_REQ-1:0]                up_d_ready,
    output logic [NUM_REQ*OP_BITS-1:0]        up_d_opcode,
    output logic [NUM_REQ*SIZE_BITS-1:0]      up_d_size,
    output logic [NUM_REQ*SOURCE_BITS-1:0]    up_d_source,
    output logic [NUM_REQ*DATA_BITS-1:0]      up_d_data,
    output logic [NUM_REQ*PB-1:0]             up_d_param,
    output logic                              mem_a_valid,
    input  logic                              mem_a_ready,
    output logic [OP_BITS-1:0]                mem_a_opcode,
    output logic [SIZE_BITS-1:0]              mem_a_size,
    output logic [ADDRESS_BITS-1:0]           mem_a_address,
    output logic [MASK_BITS-1:0]              mem_a_mask,
    output logic [DATA_BITS-1:0]              mem_a_data,
    output logic [PB-1:0]                     mem_a_param,
    output logic [SOURCE_BITS+TAG_BITS-1:0]   mem_a_source,
    input  logic                              mem_d_valid,
    output logic                              mem_d_ready,
    input  logic [OP_BITS-1:0]                mem_d_opcode,
    input  logic [SIZE_BITS-1:0]              mem_d_size,
    input  logic [DATA_BITS-1:0]              mem_d_data,
    input  logic [PB-1:0]                     mem_d_param,
    input  logic [SOURCE_BITS+TAG_BITS-1:0]   mem_d_source,
    output logic                              route_err
`ifdef L2_MEM_ARB_PERF_EN
   ,output logic [NUM_REQ*32-1:0]             perf_grant_cnt,
    output logic [31:0]                       perf_stall_cnt
`endif
);

    localparam logic [CNT_W-1:0]    MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TAG_BITS-1:0] LAST_IDX = TAG_BITS'(NUM_REQ - 1);
    localparam logic [TAG_BITS:0]   NUM_TAG  = (TAG_BITS + 1)'(NUM_REQ);

    slot_state_e         state;
    slot_state_e         state_nxt;
    logic [NUM_REQ-1:0]  elig;
    logic [NUM_REQ-1:0]  gnt;
    logic [TAG_BITS-1:0] gidx;
    logic [TAG_BITS-1:0] rr_ptr;
    logic                drain;
    logic                can_load;
    logic [NUM_REQ-1:0]  a_inc;
    logic                a_hs;
    logic [CNT_W-1:0]    cnt [NUM_REQ];
    logic [TAG_BITS-1:0] d_idx;
    logic                d_legal;
    logic [NUM_REQ-1:0]  d_hs;

    // A requester may compete only while it has room for another in-flight request
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i] = up_a_valid[i] && (cnt[i] < MAX_CNT);
        end
    end

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx)
    );

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) state <= SLOT_EMPTY;
        else     state <= state_nxt;
    end

    // Slot next state: a load wins over a drain so back-to-back traffic keeps it FULL
    always_comb begin
        state_nxt = state;
        if (a_hs)       state_nxt = SLOT_FULL;
        else if (drain) state_nxt = SLOT_EMPTY;
    end

    // Slot outputs: the slot accepts a new request when empty or draining this cycle
    always_comb begin
        mem_a_valid = (state == SLOT_FULL);
        drain       = mem_a_valid && mem_a_ready;
        can_load    = (state == SLOT_EMPTY) || drain;
        up_a_ready  = (can_load && !rst) ? gnt : '0;
        a_inc       = up_a_ready & up_a_valid;
        a_hs        = |a_inc;
    end

    // Slot payload; held while the memory side back-pressures
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_a_opcode  <= '0;
            mem_a_size    <= '0;
            mem_a_address <= '0;
            mem_a_mask    <= '0;
            mem_a_data    <= '0;
            mem_a_param   <= '0;
            mem_a_source  <= '0;
        end else if (a_hs) begin
            mem_a_opcode  <= up_a_opcode[gidx*OP_BITS +: OP_BITS];
            mem_a_size    <= up_a_size[gidx*SIZE_BITS +: SIZE_BITS];
            mem_a_address <= up_a_address[gidx*ADDRESS_BITS +: ADDRESS_BITS];
            mem_a_mask    <= up_a_mask[gidx*MASK_BITS +: MASK_BITS];
            mem_a_data    <= up_a_data[gidx*DATA_BITS +: DATA_BITS];
            mem_a_param   <= up_a_param[gidx*PB +: PB];
            mem_a_source  <= {gidx, up_a_source[gidx*SOURCE_BITS +: SOURCE_BITS]};
        end
    end

    // Round-robin pointer advances past the requester just served
    always_ff @(posedge clk) begin
        if (rst)       rr_ptr <= '0;
        else if (a_hs) rr_ptr <= (gidx == LAST_IDX) ? '0 : gidx + TAG_BITS'(1);
    end

    // D routing: steer valid/ready by tag; unknown tags are swallowed
    always_comb begin
        d_idx       = mem_d_source[SOURCE_BITS +: TAG_BITS];
        d_legal     = ({1'b0, d_idx} < NUM_TAG);
        up_d_valid  = '0;
        d_hs        = '0;
        mem_d_ready = !d_legal;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (d_legal && (d_idx == TAG_BITS'(i))) begin
                up_d_valid[i] = mem_d_valid;
                mem_d_ready   = up_d_ready[i];
                d_hs[i]       = mem_d_valid && up_d_ready[i];
            end
        end
    end

    assign up_d_opcode = {NUM_REQ{mem_d_opcode}};
    assign up_d_size   = {NUM_REQ{mem_d_size}};
    assign up_d_source = {NUM_REQ{mem_d_source[SOURCE_BITS-1:0]}};
    assign up_d_data   = {NUM_REQ{mem_d_data}};
    assign up_d_param  = {NUM_REQ{mem_d_param}};

    // Sticky flag for responses whose tag names no requester
    always_ff @(posedge clk) begin
        if (rst)                         route_err <= 1'b0;
        else if (mem_d_valid && !d_legal) route_err <= 1'b1;
    end

    // Per-requester in-flight counts; simultaneous A and D cancel out
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst)
                cnt[i] <= '0;
            else if (a_inc[i] && !d_hs[i] && (cnt[i] != '1))
                cnt[i] <= cnt[i] + CNT_W'(1);
            else if (!a_inc[i] && d_hs[i] && (cnt[i] != '0))
                cnt[i] <= cnt[i] - CNT_W'(1);
        end
    end

`ifdef L2_MEM_ARB_PERF_EN
    // Free-running grant and back-pressure counters
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (a_inc[i]) perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
            end
            if (mem_a_valid && !mem_a_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed self-checking bench for l2_mem_arbiter with three requesters.
module tb_l2_mem_arbiter;

    localparam int NR = 3;
    localparam int SB = 8;
    localparam int TB = 2;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     up_a_valid;
    logic [NR-1:0]     up_a_ready;
    logic [NR*3-1:0]   up_a_opcode;
    logic [NR*3-1:0]   up_a_size;
    logic [NR*SB-1:0]  up_a_source;
    logic [NR*32-1:0]  up_a_address;
    logic [NR*8-1:0]   up_a_mask;
    logic [NR*64-1:0]  up_a_data;
    logic [NR*3-1:0]   up_a_param;
    logic [NR-1:0]     up_d_valid;
    logic [NR-1:0]     up_d_ready;
    logic [NR*3-1:0]   up_d_opcode;
    logic [NR*3-1:0]   up_d_size;
    logic [NR*SB-1:0]  up_d_source;
    logic [NR*64-1:0]  up_d_data;
    logic [NR*3-1:0]   up_d_param;
    logic              mem_a_valid;
    logic              mem_a_ready;
    logic [2:0]        mem_a_opcode;
    logic [2:0]        mem_a_size;
    logic [31:0]       mem_a_address;
    logic [7:0]        mem_a_mask;
    logic [63:0]       mem_a_data;
    logic [2:0]        mem_a_param;
    logic [SB+TB-1:0]  mem_a_source;
    logic              mem_d_valid;
    logic              mem_d_ready;
    logic [2:0]        mem_d_opcode;
    logic [2:0]        mem_d_size;
    logic [63:0]       mem_d_data;
    logic [2:0]        mem_d_param;
    logic [SB+TB-1:0]  mem_d_source;
    logic              route_err;

    int n_chk  = 0;
    int n_fail = 0;

    l2_mem_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst),
        .up_a_valid(up_a_valid), .up_a_ready(up_a_ready),
        .up_a_opcode(up_a_opcode), .up_a_size(up_a_size), .up_a_source(up_a_source),
        .up_a_address(up_a_address), .up_a_mask(up_a_mask), .up_a_data(up_a_data),
        .up_a_param(up_a_param),
        .up_d_valid(up_d_valid), .up_d_ready(up_d_ready),
        .up_d_opcode(up_d_opcode), .up_d_size(up_d_size), .up_d_source(up_d_source),
        .up_d_data(up_d_data), .up_d_param(up_d_param),
        .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready),
        .mem_a_opcode(mem_a_opcode), .mem_a_size(mem_a_size), .mem_a_address(mem_a_address),
        .mem_a_mask(mem_a_mask), .mem_a_data(mem_a_data), .mem_a_param(mem_a_param),
        .mem_a_source(mem_a_source),
        .mem_d_valid(mem_d_valid), .mem_d_ready(mem_d_ready),
        .mem_d_opcode(mem_d_opcode), .mem_d_size(mem_d_size), .mem_d_data(mem_d_data),
        .mem_d_param(mem_d_param), .mem_d_source(mem_d_source),
        .route_err(route_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] src, input logic [31:0] addr);
        up_a_opcode[i*3 +: 3]   = 3'd4;
        up_a_size[i*3 +: 3]     = 3'd3;
        up_a_source[i*SB +: SB] = src;
        up_a_address[i*32 +: 32] = addr;
        up_a_mask[i*8 +: 8]     = 8'hFF;
        up_a_data[i*64 +: 64]   = 64'h0;
        up_a_param[i*3 +: 3]    = 3'd0;
    endtask

    task automatic send_d(input logic [1:0] tag, input logic [7:0] src, input logic [NR-1:0] rdy);
        mem_d_valid  = 1'b1;
        mem_d_source = {tag, src};
        up_d_ready   = rdy;
    endtask

    task automatic clear_d();
        mem_d_valid  = 1'b0;
        mem_d_source = '0;
        up_d_ready   = '0;
    endtask

    logic [NR-1:0] alt_exp [4];

    initial begin
        rst = 1'b1;
        up_a_valid = '0; up_a_opcode = '0; up_a_size = '0; up_a_source = '0;
        up_a_address = '0; up_a_mask = '0; up_a_data = '0; up_a_param = '0;
        up_d_ready = '0; mem_a_ready = 1'b0;
        mem_d_valid = 1'b0; mem_d_opcode = 3'd1; mem_d_size = 3'd3;
        mem_d_data = 64'hDEAD_BEEF_0123_4567; mem_d_param = '0; mem_d_source = '0;
        alt_exp[0] = 3'b001; alt_exp[1] = 3'b010; alt_exp[2] = 3'b001; alt_exp[3] = 3'b010;

        // Reset state, with a request pending that must not be accepted
        set_req(0, 8'h05, 32'h9000_0000);
        up_a_valid = 3'b001;
        repeat (3) tick();
        check_eq("rst_mem_a_valid", 64'(mem_a_valid), 64'd0);
        check_eq("rst_mem_a_addr", 64'(mem_a_address), 64'd0);
        check_eq("rst_mem_a_source", 64'(mem_a_source), 64'd0);
        check_eq("rst_up_a_ready", 64'(up_a_ready), 64'd0);
        check_eq("rst_up_d_valid", 64'(up_d_valid), 64'd0);
        check_eq("rst_route_err", 64'(route_err), 64'd0);

        // Single requester Get and its response
        rst = 1'b0;
        mem_a_ready = 1'b1;
        #1;
        check_eq("single_ready", 64'(up_a_ready), 64'b001);
        tick();
        up_a_valid = '0;
        check_eq("single_mvalid", 64'(mem_a_valid), 64'd1);
        check_eq("single_msource", 64'(mem_a_source), 64'h005);
        check_eq("single_maddr", 64'(mem_a_address), 64'h9000_0000);
        check_eq("single_mopcode", 64'(mem_a_opcode), 64'd4);
        tick();
        check_eq("single_drained", 64'(mem_a_valid), 64'd0);
        send_d(2'd0, 8'h05, 3'b001);
        #1;
        check_eq("d_valid_r0", 64'(up_d_valid), 64'b001);
        check_eq("d_source_r0", 64'(up_d_source[7:0]), 64'h05);
        check_eq("d_data_r0", 64'(up_d_data[63:0]), 64'hDEAD_BEEF_0123_4567);
        check_eq("d_ready_r0", 64'(mem_d_ready), 64'd1);
        tick();
        clear_d();

        // Fresh start so the pointer is back at r0
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Both requesters streaming: alternating grants, no bubble
        set_req(0, 8'h11, 32'h0000_1000);
        set_req(1, 8'h22, 32'h0000_2000);
        up_a_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("alt_ready_%0d", k), 64'(up_a_ready), 64'(alt_exp[k]));
            tick();
            check_eq($sformatf("alt_mvalid_%0d", k), 64'(mem_a_valid), 64'd1);
            check_eq($sformatf("alt_tag_%0d", k), 64'(mem_a_source[9:8]), 64'(k % 2));
        end
        up_a_valid = '0;
        tick();

        // Back-pressure: slot FULL with r2's request, nothing else accepted
        set_req(2, 8'h33, 32'h0000_00A0);
        up_a_valid  = 3'b100;
        mem_a_ready = 1'b0;
        #1;
        check_eq("stall_load_ready", 64'(up_a_ready), 64'b100);
        tick();
        up_a_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq($sformatf("stall_ready_%0d", k), 64'(up_a_ready), 64'd0);
            check_eq($sformatf("stall_addr_%0d", k), 64'(mem_a_address), 64'h0000_00A0);
            check_eq($sformatf("stall_src_%0d", k), 64'(mem_a_source), 64'h233);
            tick();
        end
        up_a_valid  = '0;
        mem_a_ready = 1'b1;
        tick();

        // Outstanding limit: r0 at 2 goes to 4, then is skipped while r1 proceeds
        set_req(0, 8'h44, 32'h0000_3000);
        up_a_valid = 3'b001;
        #1;
        check_eq("lim_r0_3rd", 64'(up_a_ready), 64'b001);
        tick();
        #1;
        check_eq("lim_r0_4th", 64'(up_a_ready), 64'b001);
        tick();
        up_a_valid = 3'b011;
        #1;
        check_eq("lim_r1_while_r0_full", 64'(up_a_ready), 64'b010);
        tick();
        up_a_valid = 3'b001;
        send_d(2'd0, 8'h44, 3'b001);
        #1;
        check_eq("lim_r0_blocked", 64'(up_a_ready), 64'd0);
        check_eq("lim_d_ready", 64'(mem_d_ready), 64'd1);
        tick();
        clear_d();
        #1;
        check_eq("lim_r0_reenabled", 64'(up_a_ready), 64'b001);
        tick();
        up_a_valid = '0;

        // r1 at 3: one response brings it to 2, then A and D together keep it at 2
        send_d(2'd1, 8'h22, 3'b010);
        tick();
        up_a_valid = 3'b010;
        #1;
        check_eq("same_cycle_ready", 64'(up_a_ready), 64'b010);
        check_eq("same_cycle_dvalid", 64'(up_d_valid), 64'b010);
        tick();
        clear_d();
        #1;
        check_eq("after_same_3rd", 64'(up_a_ready), 64'b010);
        tick();
        #1;
        check_eq("after_same_4th", 64'(up_a_ready), 64'b010);
        tick();
        #1;
        check_eq("after_same_blocked", 64'(up_a_ready), 64'd0);
        up_a_valid = '0;
        tick();

        // Illegal tag 3: swallowed, flagged, no counter touched
        send_d(2'd3, 8'h77, 3'b000);
        #1;
        check_eq("bad_tag_dready", 64'(mem_d_ready), 64'd1);
        check_eq("bad_tag_dvalid", 64'(up_d_valid), 64'd0);
        tick();
        clear_d();
        check_eq("bad_tag_err", 64'(route_err), 64'd1);
        up_a_valid = 3'b001;
        tick();
        check_eq("bad_tag_err_sticky", 64'(route_err), 64'd1);
        check_eq("bad_tag_r0_still_full", 64'(up_a_ready), 64'd0);

        // Reset clears the flag and all counts
        up_a_valid = '0;
        rst = 1'b1;
        tick();
        check_eq("rst2_route_err", 64'(route_err), 64'd0);
        check_eq("rst2_mem_a_valid", 64'(mem_a_valid), 64'd0);
        rst = 1'b0;
        up_a_valid = 3'b001;
        #1;
        check_eq("rst2_r0_eligible", 64'(up_a_ready), 64'b001);
        tick();
        up_a_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
